// File: rtl/ahb_pkg.sv
// AHB-Lite encodings, the image subordinate state type and lane helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HsizeByte = 3'd0,
    HsizeHalf = 3'd1,
    HsizeWord = 3'd2
  } hsize_e;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} slave_state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      HsizeByte: return 3'd1;
      HsizeHalf: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // Memory data arrives with byte A in [31:24]; shift it down to the bus lanes.
  function automatic logic [31:0] rd_justify(input logic [31:0] data, input logic [2:0] size);
    case (size)
      HsizeByte: return {24'h0, data[31:24]};
      HsizeHalf: return {16'h0, data[31:16]};
      default:   return data;
    endcase
  endfunction

  function automatic logic [31:0] wr_msb_align(input logic [31:0] wdata, input logic [2:0] size);
    case (size)
      HsizeByte: return {wdata[7:0], 24'h0};
      HsizeHalf: return {wdata[15:0], 16'h0};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ahb_image_slave_if.sv
// AHB-Lite bus bundle between the master and the image subordinate.
interface ahb_image_slave_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HTRANS, HSIZE, HADDR, HWRITE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HTRANS, HSIZE, HADDR, HWRITE, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/image_mem.sv
// Byte-addressed image store: one registered write port (bus beats side port), 4-byte async read.
module image_mem #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        bus_we_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  nbytes_i,
  input  logic [31:0] bus_wdata_i,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [7:0]  load_data_i,
  output logic [31:0] rdata_o
);
  localparam int unsigned Aw = $clog2(MEM_BYTES);

  logic [7:0]  mem_q [MEM_BYTES];
  logic [32:0] idx   [4];

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = {1'b0, addr_i} + 33'(i);
      rdata_o[31-8*i -: 8] = (idx[i] < 33'(MEM_BYTES)) ? mem_q[idx[i][Aw-1:0]] : 8'h00;
    end
  end

  // Bus bytes are written last so they win a same-byte collision with the side port.
  always_ff @(posedge clk_i) begin
    if (load_en_i && (load_addr_i < 32'(MEM_BYTES))) begin
      mem_q[load_addr_i[Aw-1:0]] <= load_data_i;
    end
    for (int i = 0; i < 4; i++) begin
      if (bus_we_i && (3'(i) < nbytes_i)) begin
        mem_q[idx[i][Aw-1:0]] <= bus_wdata_i[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_image_slave.sv
// AHB-Lite subordinate fronting the image memory: wait-state FSM, legality decode, lane mapping.
module ahb_image_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahb_image_slave_if.slave        bus,
  input  logic                    load_en,
  input  logic [31:0]             load_addr,
  input  logic [7:0]              load_data
);
  slave_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic         write_q, write_d;
  logic [2:0]   size_q, size_d;
  logic         hreadyout_q, hreadyout_d;
  logic         hresp_q, hresp_d;
  logic         stalled, accept, aligned, in_range, legal;
  logic [2:0]   req_bytes;
  logic [31:0]  mem_rdata;

  assign stalled   = (state_q == StWait) || (state_q == StErr1);
  assign accept    = bus.HSEL && bus.HREADY && !stalled &&
                     ((bus.HTRANS == HtransNonseq) || (bus.HTRANS == HtransSeq));
  assign req_bytes = size_bytes(bus.HSIZE);
  assign in_range  = ({1'b0, bus.HADDR} + 33'(req_bytes)) <= 33'(MEM_BYTES);
  assign legal     = (bus.HSIZE <= HsizeWord) && aligned && in_range;

  always_comb begin
    aligned = 1'b1;
    if (bus.HSIZE == HsizeHalf) aligned = ~bus.HADDR[0];
    if (bus.HSIZE == HsizeWord) aligned = (bus.HADDR[1:0] == 2'b00);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StData;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
    // A new accept out of DATA/ERR2 overrides the return to idle (pipelining).
    if (accept) begin
      addr_d  = bus.HADDR;
      write_d = bus.HWRITE;
      size_d  = bus.HSIZE;
      if (!legal) begin
        state_d = StErr1;
      end else if (WAIT_STATES == 0) begin
        state_d = StData;
      end else begin
        state_d = StWait;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
    hreadyout_d = !((state_d == StWait) || (state_d == StErr1));
    hresp_d     = ((state_d == StErr1) || (state_d == StErr2)) ? HrespError : HrespOkay;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HrespOkay;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = ((state_q == StData) && !write_q) ? rd_justify(mem_rdata, size_q) : 32'h0;

  image_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .clk_i       (HCLK),
    .bus_we_i    ((state_q == StData) && write_q),
    .addr_i      (addr_q),
    .nbytes_i    (size_bytes(size_q)),
    .bus_wdata_i (wr_msb_align(bus.HWDATA, size_q)),
    .load_en_i   (load_en),
    .load_addr_i (load_addr),
    .load_data_i (load_data),
    .rdata_o     (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_image_slave.sv
// Bench for ahb_image_slave: a 3-wait-state and a 0-wait-state instance checked against byte-array models.
module tb_ahb_image_slave;
  import ahb_pkg::*;

  localparam int unsigned MemBytes = 1024;
  localparam int unsigned WsSlow   = 3;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic        tgt_fast, hsel, hwrite, load_en;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, load_addr;
  logic [7:0]  load_data;
  logic        ready, resp;
  logic [31:0] rdata;

  ahb_image_slave_if bus_s ();
  ahb_image_slave_if bus_f ();

  assign bus_s.HSEL   = hsel & ~tgt_fast;
  assign bus_s.HTRANS = htrans;
  assign bus_s.HSIZE  = hsize;
  assign bus_s.HADDR  = haddr;
  assign bus_s.HWRITE = hwrite;
  assign bus_s.HWDATA = hwdata;
  assign bus_s.HREADY = bus_s.HREADYOUT;
  assign bus_f.HSEL   = hsel & tgt_fast;
  assign bus_f.HTRANS = htrans;
  assign bus_f.HSIZE  = hsize;
  assign bus_f.HADDR  = haddr;
  assign bus_f.HWRITE = hwrite;
  assign bus_f.HWDATA = hwdata;
  assign bus_f.HREADY = bus_f.HREADYOUT;

  assign ready = tgt_fast ? bus_f.HREADYOUT : bus_s.HREADYOUT;
  assign resp  = tgt_fast ? bus_f.HRESP : bus_s.HRESP;
  assign rdata = tgt_fast ? bus_f.HRDATA : bus_s.HRDATA;

  ahb_image_slave #(.MEM_BYTES(MemBytes), .WAIT_STATES(WsSlow)) u_dut_slow (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_s),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  ahb_image_slave #(.MEM_BYTES(MemBytes), .WAIT_STATES(0)) u_dut_fast (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus_f),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  logic [7:0] model [2][MemBytes];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int ws_now();
    return tgt_fast ? 0 : int'(WsSlow);
  endfunction

  function automatic bit exp_legal(input logic [31:0] a, input logic [2:0] sz);
    int n;
    if (sz > 3'd2) return 1'b0;
    n = 1 << sz;
    if ((a % n) != 0) return 1'b0;
    return ({32'h0, a} + 64'(n)) <= 64'(MemBytes);
  endfunction

  // Byte A lands in the most significant used lane; result right-justified.
  function automatic logic [31:0] exp_rdata(input int t, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << sz); i++) v = (v << 8) | {24'h0, model[t][int'(a) + i]};
    return v;
  endfunction

  task automatic model_write(input int t, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) model[t][int'(a) + i] = wd[8 * (n - 1 - i) +: 8];
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (a < MemBytes) begin
      model[0][a] = d;
      model[1][a] = d;
    end
  endtask

  // One non-pipelined transfer; reports what the bus showed, bounded wait for HREADYOUT.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output int st, output logic sr, output logic fr, output logic [31:0] frd,
                      output bit nz, output bit to);
    hsel = 1'b1; htrans = HtransNonseq; haddr = a; hsize = sz; hwrite = wr;
    tick();
    hsel = 1'b0; htrans = HtransIdle; hwdata = wd;
    st = 0; sr = 1'b0; nz = 1'b0; to = 1'b0;
    while (ready !== 1'b1 && st < 32) begin
      sr = sr | resp;
      if (rdata !== 32'h0) nz = 1'b1;
      st++;
      tick();
    end
    to  = (st >= 32);
    fr  = resp;
    frd = rdata;
    tick();
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    #1;
    n_checks++;
    if (bus_s.HREADYOUT !== 1'b1 || bus_s.HRESP !== 1'b0 || bus_s.HRDATA !== 32'h0 ||
        bus_f.HREADYOUT !== 1'b1 || bus_f.HRESP !== 1'b0 || bus_f.HRDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: slow=%b/%b/%h fast=%b/%b/%h, required 1/0/00000000",
               bus_s.HREADYOUT, bus_s.HRESP, bus_s.HRDATA, bus_f.HREADYOUT, bus_f.HRESP, bus_f.HRDATA);
    end
    tick(); tick();
    HRESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tgt_fast = i[0];
      hsel     = (i < 4);
      htrans   = (i < 2) ? HtransIdle : ((i < 4) ? HtransBusy : HtransNonseq);
      tick();
      n_checks++;
      if (ready !== 1'b1 || resp !== 1'b0 || rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_okay[%0d]: rdy=%b resp=%b rdata=%h, required 1/0/00000000",
                 i, ready, resp, rdata);
      end
    end
    hsel = 1'b0; htrans = HtransIdle;
  endtask

  task automatic test_word_read();
    int st; logic sr, fr; logic [31:0] frd; bit nz, to;
    load_byte(0, 8'h3E); load_byte(1, 8'h9D); load_byte(2, 8'h13); load_byte(3, 8'hE1);
    for (int t = 0; t < 2; t++) begin
      tgt_fast = t[0];
      xfer(1'b0, 32'h0, HsizeWord, 32'h0, st, sr, fr, frd, nz, to);
      n_checks++;
      if (to || st != ws_now() || sr !== 1'b0 || nz || fr !== 1'b0 || frd !== 32'h3E9D13E1) begin
        n_fail++;
        $display("FAIL word_read[%0d]: stalls=%0d resp=%b/%b rdata=%h, required stalls=%0d resp=0/0 rdata=3e9d13e1",
                 t, st, sr, fr, frd, ws_now());
      end
    end
  endtask

  task automatic test_half_write();
    int st; logic sr, fr; logic [31:0] frd; bit nz, to;
    logic [31:0] exp_rd [4] = '{32'h0, 32'h1220_0000, 32'h0000_0020, 32'h0000_5A7C};
    tgt_fast = 1'b0;
    load_byte(102, 8'h00); load_byte(103, 8'h00);
    for (int k = 0; k < 4; k++) begin
      unique case (k)
        0: xfer(1'b1, 32'd100, HsizeHalf, 32'h0000_1220, st, sr, fr, frd, nz, to);
        1: xfer(1'b0, 32'd100, HsizeWord, 32'h0, st, sr, fr, frd, nz, to);
        2: begin
          xfer(1'b1, 32'd104, HsizeHalf, 32'hDEAD_5A7C, st, sr, fr, frd, nz, to);
          xfer(1'b0, 32'd101, HsizeByte, 32'h0, st, sr, fr, frd, nz, to);
        end
        default: xfer(1'b0, 32'd104, HsizeHalf, 32'h0, st, sr, fr, frd, nz, to);
      endcase
      n_checks++;
      if (to || st != int'(WsSlow) || sr !== 1'b0 || fr !== 1'b0 || nz || frd !== exp_rd[k]) begin
        n_fail++;
        $display("FAIL half_write[%0d]: stalls=%0d resp=%b/%b rdata=%h, required stalls=%0d resp=0/0 rdata=%h",
                 k, st, sr, fr, frd, WsSlow, exp_rd[k]);
      end
    end
    model[0][100] = 8'h12; model[0][101] = 8'h20; model[0][104] = 8'h5A; model[0][105] = 8'h7C;
  endtask

  task automatic test_back_to_back();
    logic        op_wr [24];
    logic [31:0] op_a  [24];
    logic [2:0]  op_sz [24];
    logic [31:0] op_wd [24];
    logic [31:0] exp_rd;
    tgt_fast = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 3) begin
        op_wr[i] = 1'b0; op_a[i] = 32'(4 * i); op_sz[i] = HsizeWord;
      end else begin
        op_wr[i] = 1'($urandom_range(0, 1));
        op_sz[i] = 3'($urandom_range(0, 2));
        op_a[i]  = 32'($urandom_range(0, 15)) & ~((32'd1 << op_sz[i]) - 32'd1);
      end
      op_wd[i] = $urandom;
    end
    for (int c = 0; c <= 24; c++) begin
      if (c < 24) begin
        hsel = 1'b1; htrans = HtransNonseq; haddr = op_a[c]; hsize = op_sz[c]; hwrite = op_wr[c];
      end else begin
        hsel = 1'b0; htrans = HtransIdle;
      end
      if (c > 0) begin
        hwdata = op_wd[c-1];
        exp_rd = op_wr[c-1] ? 32'h0 : exp_rdata(1, op_a[c-1], op_sz[c-1]);
        n_checks++;
        if (ready !== 1'b1 || resp !== 1'b0 || rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: rdy=%b resp=%b rdata=%h, required 1/0/%h",
                   c - 1, ready, resp, rdata, exp_rd);
        end
      end
      tick();
      if (c > 0 && op_wr[c-1]) model_write(1, op_a[c-1], op_sz[c-1], op_wd[c-1]);
    end
  endtask

  task automatic test_errors();
    int st; logic sr, fr; logic [31:0] frd; bit nz, to;
    logic [31:0] a, wd, exp_rd;
    logic [2:0]  sz;
    bit wr, exp_ok;
    tgt_fast = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) begin
        wr = 1'b0; a = 32'd2; sz = HsizeWord;
      end else if (k == 1) begin
        wr = 1'b1; a = MemBytes - 1; sz = HsizeHalf;
      end else if (k == 2) begin
        wr = 1'b0; a = MemBytes - 4; sz = HsizeWord;
      end else begin
        wr = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0:       a = 32'($urandom_range(0, 63));
          1:       a = MemBytes - 32'($urandom_range(1, 6));
          2:       a = $urandom;
          default: a = 32'($urandom_range(0, MemBytes - 1));
        endcase
      end
      wd     = $urandom;
      exp_ok = exp_legal(a, sz);
      exp_rd = (exp_ok && !wr) ? exp_rdata(0, a, sz) : 32'h0;
      xfer(wr, a, sz, wd, st, sr, fr, frd, nz, to);
      if (exp_ok && wr) model_write(0, a, sz, wd);
      n_checks++;
      if (to || st != (exp_ok ? int'(WsSlow) : 1) || sr !== !exp_ok || fr !== !exp_ok || nz ||
          frd !== exp_rd) begin
        n_fail++;
        $display("FAIL error_resp[%0d] wr=%0b a=%h sz=%0d: stalls=%0d resp=%b/%b rdata=%h, required stalls=%0d resp=%b/%b rdata=%h",
                 k, wr, a, sz, st, sr, fr, frd, exp_ok ? int'(WsSlow) : 1, !exp_ok, !exp_ok, exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st; logic sr, fr; logic [31:0] frd; bit nz, to;
    logic [31:0] exp_rd;
    tgt_fast = 1'b0;
    exp_rd = exp_rdata(0, 32'h0, HsizeWord);
    hsel = 1'b1; htrans = HtransNonseq; haddr = 32'h0; hsize = HsizeWord; hwrite = 1'b1;
    tick();
    hsel = 1'b0; htrans = HtransIdle; hwdata = 32'hAABB_CCDD;
    tick();
    HRESET = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b1 || resp !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b resp=%b rdata=%h, required 1/0/00000000",
               ready, resp, rdata);
    end
    tick();
    HRESET = 1'b0;
    tick();
    xfer(1'b0, 32'h0, HsizeWord, 32'h0, st, sr, fr, frd, nz, to);
    n_checks++;
    if (to || fr !== 1'b0 || frd !== exp_rd) begin
      n_fail++;
      $display("FAIL reset_mid_no_commit: rdata=%h resp=%b, required rdata=%h resp=0", frd, fr, exp_rd);
    end
  endtask

  task automatic test_side_port();
    int st; logic sr, fr; logic [31:0] frd; bit nz, to;
    logic [7:0] old5;
    tgt_fast = 1'b0;
    hsel = 1'b1; htrans = HtransNonseq; haddr = 32'd20; hsize = HsizeByte; hwrite = 1'b1;
    tick();
    hsel = 1'b0; htrans = HtransIdle; hwdata = 32'h0000_0077;
    for (int i = 0; i < int'(WsSlow); i++) tick();
    load_en = 1'b1; load_addr = 32'd20; load_data = 8'h55;
    tick();
    load_en = 1'b0;
    model[0][20] = 8'h77;
    model[1][20] = 8'h55;
    for (int t = 0; t < 2; t++) begin
      tgt_fast = t[0];
      xfer(1'b0, 32'd20, HsizeByte, 32'h0, st, sr, fr, frd, nz, to);
      n_checks++;
      if (to || fr !== 1'b0 || frd !== ((t == 0) ? 32'h77 : 32'h55)) begin
        n_fail++;
        $display("FAIL side_collision[%0d]: rdata=%h, required %h", t, frd, (t == 0) ? 32'h77 : 32'h55);
      end
    end
    old5 = model[0][5];
    load_byte(MemBytes + 5, ~old5);
    load_byte(32'h0001_0005, ~old5);
    tgt_fast = 1'b0;
    xfer(1'b0, 32'd5, HsizeByte, 32'h0, st, sr, fr, frd, nz, to);
    n_checks++;
    if (to || frd !== {24'h0, old5}) begin
      n_fail++;
      $display("FAIL load_out_of_range: rdata=%h, required %h", frd, {24'h0, old5});
    end
  endtask

  initial begin
    tgt_fast = 1'b0; hsel = 1'b0; htrans = HtransIdle; hsize = HsizeByte; haddr = 32'h0;
    hwrite = 1'b0; hwdata = 32'h0; load_en = 1'b0; load_addr = 32'h0; load_data = 8'h0;
    test_reset();
    for (int i = 0; i < int'(MemBytes); i++) load_byte(32'(i), 8'($urandom));
    test_word_read();
    test_half_write();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_side_port();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
